uart_pixel_packer: RTL and testbench
====================================

UART_PIXEL_PACKER -- requirements
Module: uart_pixel_packer

Interface
REQ-001 Parameter BPP, default 2: bytes per pixel; legal range 1..4.
REQ-002 Parameter OUT_W, default 24: width of the output pixel word.
REQ-003 Parameter MSB_FIRST, default 1: 1 means the first received byte is the most significant byte; 0 means least significant first.
REQ-004 Parameter EXPAND565, default 1: 1 means RGB565-to-RGB888 expansion; it is effective only when BPP==2 and OUT_W==24.
REQ-005 Parameter FRAME_PIX, default 130560: pixels per frame (480x272).
REQ-006 Parameter TIMEOUT, default 50000: maximum idle cycles allowed between bytes of one pixel.
REQ-007 Port sclk, input, 1 bit: single clock; every register is clocked on its rising edge.
REQ-008 Port s_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port in_data, input, 8 bits: received byte.
REQ-010 Port in_flag, input, 1 bit: one-cycle strobe marking in_data as valid.
REQ-011 Port sync_clr, input, 1 bit: synchronous soft clear.
REQ-012 Port out_data, output, OUT_W bits: assembled pixel.
REQ-013 Port out_valid, output, 1 bit: out_data holds a pixel.
REQ-014 Port out_ready, input, 1 bit: the consumer accepts a pixel in any cycle where out_valid and out_ready are both high.
REQ-015 Port frame_done, output, 1 bit: one-cycle pulse at the end of a frame.
REQ-016 Port pix_cnt, output, ceil(log2(FRAME_PIX)) bits: index of the next pixel within the current frame.
REQ-017 Port overflow, output, 1 bit: sticky flag, set when a pixel is dropped.
REQ-018 Port resync_err, output, 1 bit: one-cycle pulse when a partial pixel is discarded on timeout.

Function
REQ-019 The FSM SHALL have two states:
- IDLE: no bytes held.
- COLLECT: 1..BPP-1 bytes held, tracked by a byte index.
REQ-020 Byte accumulation:
- in_flag in IDLE stores the byte and moves to COLLECT.
- in_flag in COLLECT stores the byte and increments the index.
- The byte that completes BPP bytes forms the pixel and returns the FSM to IDLE.
- When BPP==1, every in_flag completes a pixel and the FSM stays in IDLE.
REQ-021 Byte placement: MSB_FIRST=1 shifts each byte in from the LSB side; MSB_FIRST=0 places byte k at bits [8k+7:8k].
REQ-022 When EXPAND565 is effective, with assembled word w, out_data SHALL be {w[15:11],w[15:13], w[10:5],w[10:9], w[4:0],w[4:2]}.
REQ-023 Otherwise the assembled BPP*8-bit word SHALL be zero-extended to OUT_W, or truncated keeping its LSBs.
REQ-024 Latency: final byte on in_flag at cycle N -> out_valid=1 with the pixel on out_data at cycle N+1.
REQ-025 Output holding: out_valid and out_data SHALL stay stable until accepted; out_valid falls the cycle after acceptance unless a new pixel loads in that same cycle.
REQ-026 A pixel completing in the same cycle the held pixel is accepted SHALL load with no gap and no overflow.
REQ-027 Dropped pixel:
- Condition: a pixel completes while out_valid=1 and out_ready=0.
- The new pixel is discarded and the held pixel is retained.
- overflow is set and pix_cnt does not advance.
REQ-028 Pixel counting: pix_cnt SHALL increment on each pixel load into the output register.
REQ-029 On the load that makes the count equal FRAME_PIX: pix_cnt wraps to 0, and frame_done pulses in the same cycle out_valid asserts for that pixel.
REQ-030 Timeout counter: counts cycles in COLLECT and restarts at 0 on every in_flag.
REQ-031 Timeout expiry: on reaching TIMEOUT-1 with no in_flag, the held bytes are discarded, the FSM returns to IDLE, and resync_err pulses for one cycle.
REQ-032 in_flag arriving in the expiry cycle SHALL take precedence: the byte is accepted and no timeout occurs.
REQ-033 sync_clr=1 SHALL clear all of the following in the next cycle: FSM (to IDLE), byte index, timeout counter, pix_cnt, overflow, out_valid.
REQ-034 sync_clr SHALL take precedence over a simultaneous in_flag, and that byte is dropped.
REQ-035 overflow SHALL clear only on reset or sync_clr.

Reset
REQ-036 While s_rst_n=0, all of the following SHALL be 0 immediately and asynchronously: out_data, out_valid, frame_done, pix_cnt, overflow, resync_err, byte index, timeout counter; the FSM is in IDLE.
REQ-037 Assertion of reset mid-pixel SHALL discard partial bytes.
REQ-038 The first in_flag after reset release SHALL be treated as byte 0 of a new pixel.

Verification
REQ-039 Format: defaults, out_ready=1; bytes F8,00 / 07,E0 / 00,1F -> out_data 0xFF0000 / 0x00FF00 / 0x0000FF, each one cycle after the second byte.
REQ-040 Byte order: BPP=3, OUT_W=24, MSB_FIRST=0; bytes 11,22,33 -> out_data 0x332211.
REQ-041 Timeout: TIMEOUT=16; byte AB, 16 idle cycles, then F8,00 -> resync_err pulses once, then out_data=0xFF0000.
REQ-042 Overflow: out_ready=0; pixels F800 then 001F -> out_data stays 0xFF0000, overflow=1, pix_cnt=1; then raise out_ready -> accepted, out_valid=0 the following cycle.
REQ-043 Frame wrap: FRAME_PIX=4; 5 pixels -> frame_done pulses with pixel 4 only, pix_cnt sequence 1,2,3,0,1.
REQ-044 Reset and clear: assert s_rst_n=0 after byte F8, release, send 07,E0 -> out_data=0x00FF00; sync_clr coincident with in_flag -> that byte is ignored.

Source files
------------

// File: rtl/uart_pixel_packer.sv
// Packs a stream of UART bytes into pixel words with optional RGB565->RGB888 expansion,
// frame counting, inter-byte timeout recovery and a single-entry output holding register.
module uart_pixel_packer #(
    parameter int unsigned BPP       = 2,
    parameter int unsigned OUT_W     = 24,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned EXPAND565 = 1,
    parameter int unsigned FRAME_PIX = 130560,
    parameter int unsigned TIMEOUT   = 50000,
    localparam int unsigned CNT_W    = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_flag,
    input  logic             sync_clr,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_done,
    output logic [CNT_W-1:0] pix_cnt,
    output logic             overflow,
    output logic             resync_err
);

    localparam int unsigned WORD_W = BPP * 8;
    localparam int unsigned IDX_W  = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          EXP_ON = (EXPAND565 != 0) && (BPP == 2) && (OUT_W == 24);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [TCNT_W-1:0]  tcnt;
    logic [WORD_W-1:0]  acc;

    logic [WORD_W-1:0]  word_c;
    logic [OUT_W-1:0]   pixel_c;
    logic               last_c;
    logic               load_c;
    logic               drop_c;
    logic               expire_c;
    logic               wrap_c;

    // Word as it would look with the incoming byte merged in
    always_comb begin
        word_c = acc;
        if (MSB_FIRST != 0) begin
            word_c = WORD_W'({acc, in_data});
        end else begin
            word_c = (acc & ~(WORD_W'(8'hFF) << {idx, 3'b000}))
                   | (WORD_W'(in_data) << {idx, 3'b000});
        end
    end

    generate
        if (EXP_ON) begin : g_565
            assign pixel_c = {word_c[15:11], word_c[15:13],
                              word_c[10:5],  word_c[10:9],
                              word_c[4:0],   word_c[4:2]};
        end else begin : g_raw
            assign pixel_c = OUT_W'(word_c);
        end
    endgenerate

    // Completion, load/drop and timeout decisions for the current cycle
    always_comb begin
        last_c   = (BPP == 1) || ((state == COLLECT) && (idx == IDX_W'(BPP - 1)));
        load_c   = in_flag && last_c && (!out_valid || out_ready);
        drop_c   = in_flag && last_c && out_valid && !out_ready;
        expire_c = (state == COLLECT) && !in_flag && (tcnt == TCNT_W'(TIMEOUT - 1));
        wrap_c   = (pix_cnt == CNT_W'(FRAME_PIX - 1));
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            tcnt       <= '0;
            acc        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            pix_cnt    <= '0;
            overflow   <= 1'b0;
            resync_err <= 1'b0;
        end else if (sync_clr) begin
            state      <= IDLE;
            idx        <= '0;
            tcnt       <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            pix_cnt    <= '0;
            overflow   <= 1'b0;
            resync_err <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            resync_err <= 1'b0;

            // Byte accumulation; an arriving byte always beats the timeout
            if (in_flag) begin
                acc  <= word_c;
                tcnt <= '0;
                if (last_c) begin
                    state <= IDLE;
                    idx   <= '0;
                end else begin
                    state <= COLLECT;
                    idx   <= idx + 1'b1;
                end
            end else if (state == COLLECT) begin
                if (expire_c) begin
                    state      <= IDLE;
                    idx        <= '0;
                    tcnt       <= '0;
                    resync_err <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end

            // Output holding register; a load in the acceptance cycle keeps valid high
            if (load_c) begin
                out_data   <= pixel_c;
                out_valid  <= 1'b1;
                frame_done <= wrap_c;
                pix_cnt    <= wrap_c ? '0 : pix_cnt + 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Bench for uart_pixel_packer: directed scenarios plus random traffic against a queue-based model.
module tb_uart_pixel_packer;

    localparam int unsigned FP = 4;
    localparam int unsigned TO = 16;

    logic        sclk    = 1'b0;
    logic        s_rst_n = 1'b0;

    logic [7:0]  data_a;
    logic        flag_a, clr_a, rdy_a;
    logic [23:0] out_data_a;
    logic        valid_a, fd_a, ovf_a, rerr_a;
    logic [1:0]  pix_a;

    logic [7:0]  data_b;
    logic        flag_b, clr_b, rdy_b;
    logic [23:0] out_data_b;
    logic        valid_b, fd_b, ovf_b, rerr_b;
    logic [1:0]  pix_b;

    int n_checks = 0;
    int n_pass   = 0;

    byte unsigned mq[$];
    int           m_idle;
    bit           m_valid, m_ovf, m_fd, m_rerr;
    int unsigned  m_data;
    int           m_pix;

    always #5 sclk = ~sclk;

    uart_pixel_packer #(
        .BPP(2), .OUT_W(24), .MSB_FIRST(1), .EXPAND565(1), .FRAME_PIX(FP), .TIMEOUT(TO)
    ) u_dut_a (
        .sclk(sclk), .s_rst_n(s_rst_n), .in_data(data_a), .in_flag(flag_a),
        .sync_clr(clr_a), .out_data(out_data_a), .out_valid(valid_a), .out_ready(rdy_a),
        .frame_done(fd_a), .pix_cnt(pix_a), .overflow(ovf_a), .resync_err(rerr_a)
    );

    uart_pixel_packer #(
        .BPP(3), .OUT_W(24), .MSB_FIRST(0), .EXPAND565(1), .FRAME_PIX(FP), .TIMEOUT(TO)
    ) u_dut_b (
        .sclk(sclk), .s_rst_n(s_rst_n), .in_data(data_b), .in_flag(flag_b),
        .sync_clr(clr_b), .out_data(out_data_b), .out_valid(valid_b), .out_ready(rdy_b),
        .frame_done(fd_b), .pix_cnt(pix_b), .overflow(ovf_b), .resync_err(rerr_b)
    );

    function automatic int unsigned expand565(int unsigned w);
        int unsigned r, g, b;
        r = (w >> 11) & 31;
        g = (w >> 5) & 63;
        b = w & 31;
        return (((r << 3) | (r >> 2)) << 16) | (((g << 2) | (g >> 4)) << 8) | ((b << 3) | (b >> 2));
    endfunction

    task automatic model_reset();
        mq.delete();
        m_idle  = 0;
        m_valid = 0;
        m_data  = 0;
        m_pix   = 0;
        m_ovf   = 0;
        m_fd    = 0;
        m_rerr  = 0;
    endtask

    // One clock of the reference behaviour for instance A
    task automatic model_step(bit f, byte unsigned d, bit clr, bit rdy);
        bit          taken;
        bit          loaded;
        int unsigned w;
        if (clr) begin
            mq.delete();
            m_idle  = 0;
            m_valid = 0;
            m_pix   = 0;
            m_ovf   = 0;
            m_fd    = 0;
            m_rerr  = 0;
            return;
        end
        taken  = m_valid && rdy;
        loaded = 0;
        m_fd   = 0;
        m_rerr = 0;
        if (f) begin
            mq.push_back(d);
            m_idle = 0;
            if (mq.size() == 2) begin
                w = int'(mq[0]) * 256 + int'(mq[1]);
                mq.delete();
                if (!m_valid || rdy) begin
                    m_data  = expand565(w);
                    m_valid = 1;
                    m_pix   = (m_pix + 1) % FP;
                    m_fd    = (m_pix == 0);
                    loaded  = 1;
                end else begin
                    m_ovf = 1;
                end
            end
        end else if (mq.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                mq.delete();
                m_idle = 0;
                m_rerr = 1;
            end
        end
        if (taken && !loaded) m_valid = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_a();
        chk("valid", 32'(valid_a), 32'(m_valid));
        chk("data", 32'(out_data_a), m_data);
        chk("pix_cnt", 32'(pix_a), 32'(m_pix));
        chk("overflow", 32'(ovf_a), 32'(m_ovf));
        chk("frame_done", 32'(fd_a), 32'(m_fd));
        chk("resync_err", 32'(rerr_a), 32'(m_rerr));
    endtask

    task automatic tick();
        bit          f, c, r;
        byte unsigned d;
        f = flag_a;
        c = clr_a;
        r = rdy_a;
        d = data_a;
        @(posedge sclk);
        model_step(f, d, c, r);
        #1;
        check_a();
    endtask

    task automatic send_a(input logic [7:0] d);
        flag_a = 1'b1;
        data_a = d;
        tick();
        flag_a = 1'b0;
    endtask

    task automatic pixel_a(input logic [7:0] hi, input logic [7:0] lo);
        send_a(hi);
        send_a(lo);
    endtask

    task automatic send_b(input logic [7:0] d);
        flag_b = 1'b1;
        data_b = d;
        tick();
        flag_b = 1'b0;
    endtask

    initial begin
        int          exp_seq[5];
        logic [7:0]  b0, b1, b2;
        exp_seq = '{1, 2, 3, 0, 1};
        flag_a = 0; data_a = 0; clr_a = 0; rdy_a = 1;
        flag_b = 0; data_b = 0; clr_b = 0; rdy_b = 1;
        model_reset();

        // Reset state
        #12;
        check_a();
        chk("b_reset_valid", 32'(valid_b), 32'h0);
        chk("b_reset_data", 32'(out_data_b), 32'h0);
        @(negedge sclk);
        s_rst_n = 1'b1;
        tick();

        // RGB565 expansion of pure primaries
        pixel_a(8'hF8, 8'h00);
        chk("fmt_red", 32'(out_data_a), 32'hFF0000);
        chk("fmt_red_valid", 32'(valid_a), 32'h1);
        pixel_a(8'h07, 8'hE0);
        chk("fmt_green", 32'(out_data_a), 32'h00FF00);
        pixel_a(8'h00, 8'h1F);
        chk("fmt_blue", 32'(out_data_a), 32'h0000FF);

        // Timeout discards a lone byte after TO idle cycles
        send_a(8'hAB);
        repeat (TO - 1) tick();
        chk("rerr_early", 32'(rerr_a), 32'h0);
        tick();
        chk("rerr_pulse", 32'(rerr_a), 32'h1);
        tick();
        chk("rerr_one_cycle", 32'(rerr_a), 32'h0);
        pixel_a(8'hF8, 8'h00);
        chk("after_timeout", 32'(out_data_a), 32'hFF0000);

        // Byte landing in the expiry cycle wins over the timeout
        send_a(8'h12);
        repeat (TO - 1) tick();
        send_a(8'h34);
        chk("prec_valid", 32'(valid_a), 32'h1);
        chk("prec_data", 32'(out_data_a), 32'h1045A5);

        // Overflow with consumer stalled
        clr_a = 1; tick(); clr_a = 0;
        rdy_a = 0;
        pixel_a(8'hF8, 8'h00);
        pixel_a(8'h00, 8'h1F);
        chk("ovf_data_held", 32'(out_data_a), 32'hFF0000);
        chk("ovf_flag", 32'(ovf_a), 32'h1);
        chk("ovf_pix", 32'(pix_a), 32'h1);
        rdy_a = 1;
        tick();
        chk("ovf_accept_valid", 32'(valid_a), 32'h0);
        chk("ovf_sticky", 32'(ovf_a), 32'h1);

        // Frame wrap with FRAME_PIX=4
        clr_a = 1; tick(); clr_a = 0;
        for (int i = 0; i < 5; i++) begin
            pixel_a(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            chk("wrap_pix", 32'(pix_a), 32'(exp_seq[i]));
            chk("wrap_fd", 32'(fd_a), (i == 3) ? 32'h1 : 32'h0);
        end

        // sync_clr beats a coincident byte
        send_a(8'hF8);
        clr_a = 1; flag_a = 1; data_a = 8'h00;
        tick();
        clr_a = 0; flag_a = 0;
        chk("clr_valid", 32'(valid_a), 32'h0);
        chk("clr_pix", 32'(pix_a), 32'h0);
        pixel_a(8'h07, 8'hE0);
        chk("clr_then_green", 32'(out_data_a), 32'h00FF00);

        // Reset mid-pixel
        send_a(8'hF8);
        s_rst_n = 1'b0;
        #1;
        model_reset();
        check_a();
        @(negedge sclk);
        s_rst_n = 1'b1;
        pixel_a(8'h07, 8'hE0);
        chk("rst_then_green", 32'(out_data_a), 32'h00FF00);

        // Instance B: three bytes, least significant first
        send_b(8'h11); send_b(8'h22); send_b(8'h33);
        chk("b_order", 32'(out_data_b), 32'h332211);
        chk("b_valid", 32'(valid_b), 32'h1);
        for (int i = 0; i < 3; i++) begin
            b0 = 8'($urandom_range(0, 255));
            b1 = 8'($urandom_range(0, 255));
            b2 = 8'($urandom_range(0, 255));
            send_b(b0); send_b(b1); send_b(b2);
            chk("b_rand", 32'(out_data_b), 32'(b0) + (32'(b1) << 8) + (32'(b2) << 16));
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                flag_a = 0; clr_a = 0;
                repeat ($urandom_range(10, 20)) tick();
            end
            flag_a = 1'($urandom_range(0, 1));
            data_a = 8'($urandom_range(0, 255));
            rdy_a  = ($urandom_range(0, 3) != 0);
            clr_a  = ($urandom_range(0, 63) == 0);
            tick();
        end
        flag_a = 0; clr_a = 0; rdy_a = 1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
